change_dispenser: RTL

Pays out a change amount from the vending controller as discrete coin-eject pulses to the three coin hoppers ($5, $2, $1). It is the output-side counterpart of the coin-input path: the controller hands it the computed change, and it drives the hopper solenoids greedily, largest coin first. If a hopper is empty it falls back to smaller denominations. It reports completion, or an unpayable remainder, back to the controller.

---
 rtl/change_dispenser.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays out a change amount as discrete coin-eject pulses to the
//            $5, $2 and $1 hoppers, largest coin first, falling back to
//            smaller coins when a hopper reports empty. Reports completion
//            or an unpayable remainder back to the vending controller.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start, amount     - pay request and amount (dollars), IDLE only
//            empty5/2/1        - hopper-empty flags, sampled in SELECT only
//            eject5/2/1        - registered hopper solenoid drives (one-hot0)
//            busy              - high while not IDLE
//            done, error       - one-cycle completion / unpayable pulses
//            remaining         - amount still owed (held after completion)
//            coin_count        - coins ejected for the current request
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic             empty5,
  input  logic             empty2,
  input  logic             empty1,
  output logic             eject5,
  output logic             eject2,
  output logic             eject1,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] remaining,
  output logic [WIDTH-1:0] coin_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EJECT  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    COIN1 = 2'd0,
    COIN2 = 2'd1,
    COIN5 = 2'd2
  } coin_t;

  // One down-counter serves both the pulse and the gap phases.
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0]    c_pulse_last = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]    c_gap_last   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WIDTH-1:0] c_val5       = WIDTH'(5);
  localparam logic [WIDTH-1:0] c_val2       = WIDTH'(2);
  localparam logic [WIDTH-1:0] c_val1       = WIDTH'(1);

  state_t           r_state, w_state_next;
  coin_t            r_coin, w_coin_next;
  logic [CW-1:0]    r_timer, w_timer_next;
  logic [WIDTH-1:0] w_remaining_next;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_coin_value;

  always_comb begin
    case (r_coin)
      COIN5:   w_coin_value = c_val5;
      COIN2:   w_coin_value = c_val2;
      default: w_coin_value = c_val1;
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_coin_next      = r_coin;
    w_timer_next     = r_timer;
    w_remaining_next = remaining;
    w_count_next     = coin_count;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_remaining_next = amount;
          w_count_next     = '0;
          w_state_next     = SELECT;
        end
      end

      SELECT: begin
        w_timer_next = c_pulse_last;
        if (remaining == '0) begin
          w_state_next = DONE;
        end else if (remaining >= c_val5 && !empty5) begin
          w_coin_next  = COIN5;
          w_state_next = EJECT;
        end else if (remaining >= c_val2 && !empty2) begin
          w_coin_next  = COIN2;
          w_state_next = EJECT;
        end else if (remaining >= c_val1 && !empty1) begin
          w_coin_next  = COIN1;
          w_state_next = EJECT;
        end else begin
          w_state_next = ERROR;
        end
      end

      EJECT: begin
        if (r_timer == '0) begin
          // The coin is committed on the last pulse cycle; it was only
          // selected when remaining >= its value, so no underflow.
          w_remaining_next = remaining - w_coin_value;
          w_count_next     = (coin_count == '1) ? coin_count : coin_count + 1'b1;
          w_timer_next     = c_gap_last;
          w_state_next     = (GAP_CYCLES == 0) ? SELECT : GAP;
        end else begin
          w_timer_next = r_timer - 1'b1;
        end
      end

      GAP: begin
        if (r_timer == '0) begin
          w_state_next = SELECT;
        end else begin
          w_timer_next = r_timer - 1'b1;
        end
      end

      DONE:    w_state_next = IDLE;
      ERROR:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // All outputs are registered from the next-state decode so the hopper
  // drives carry no combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_coin     <= COIN1;
      r_timer    <= '0;
      remaining  <= '0;
      coin_count <= '0;
      eject5     <= 1'b0;
      eject2     <= 1'b0;
      eject1     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_coin     <= w_coin_next;
      r_timer    <= w_timer_next;
      remaining  <= w_remaining_next;
      coin_count <= w_count_next;
      eject5     <= (w_state_next == EJECT) && (w_coin_next == COIN5);
      eject2     <= (w_state_next == EJECT) && (w_coin_next == COIN2);
      eject1     <= (w_state_next == EJECT) && (w_coin_next == COIN1);
      busy       <= (w_state_next != IDLE);
      done       <= (w_state_next == DONE);
      error      <= (w_state_next == ERROR);
    end
  end

endmodule
`default_nettype wire
